dcache_req_arbiter: RTL and testbench
=====================================

DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

Interface
REQ-001 Parameters (name, default, meaning): OWNER_DEPTH, 4, owner-FIFO entries (power of 2, >=2); STARVE_LIMIT, 8, consecutive PTW grants before a forced core grant.
REQ-002 Ports (name, direction, width, meaning): clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-003 ptw_req_valid_i in 1, ptw_req_addr_i in 40, ptw_req_typ_i in 4, ptw_req_kill_i in 1 (PTW request); ptw_req_ready_o out 1.
REQ-004 ptw_resp_valid_o out 1, ptw_resp_data_o out 64, ptw_resp_nack_o out 1 (response to PTW).
REQ-005 core_req_valid_i in 1, core_req_addr_i in 40, core_req_data_i in 64, core_req_cmd_i in 5, core_req_typ_i in 4, core_req_kill_i in 1; core_req_ready_o out 1.
REQ-006 core_resp_valid_o out 1, core_resp_data_o out 64, core_resp_nack_o out 1.
REQ-007 dc_req_valid_o out 1, dc_req_addr_o out 40, dc_req_data_o out 64, dc_req_cmd_o out 5, dc_req_typ_o out 4, dc_req_kill_o out 1, dc_req_phys_o out 1; dc_req_ready_i in 1.
REQ-008 dc_resp_valid_i in 1, dc_resp_data_i in 64, dc_resp_nack_i in 1 (in-order responses); flush_i in 1 (sfence/satp write); orphan_err_o out 1 (sticky).
REQ-009 Clock is clk_i; reset rst_ni is asynchronous, active-low; single clock domain.

Function
REQ-010 Request path is combinational; a grant occurs when dc_req_valid_o && dc_req_ready_i.
REQ-011 Candidates: replay slot (if occupied), then PTW, then core; fixed priority except REQ-013.
REQ-012 No request is presented (dc_req_valid_o=0, both readys=0) while the owner FIFO is full.
REQ-013 Starvation counter increments on each PTW/replay grant while core_req_valid_i=1, clears on core grant or when core idle; at STARVE_LIMIT the core takes priority for one grant.
REQ-014 PTW grants drive dc_req_cmd_o=0 (load), dc_req_data_o=0, dc_req_phys_o=1; core grants drive phys=0 and pass cmd/data.
REQ-015 ptw_req_ready_o / core_req_ready_o are asserted only for the selected requester and equal dc_req_ready_i for it.
REQ-016 Each grant pushes owner bit (1=PTW) into the owner FIFO; each dc_resp_valid_i pops it; push and pop in same cycle keep occupancy unchanged, including when full.
REQ-017 Response routed by popped owner bit; data/nack copied same cycle; non-owner valid stays 0.
REQ-018 dc_resp_valid_i with empty FIFO: response dropped, orphan_err_o set until reset.
REQ-019 Kill inputs pass to dc_req_kill_o for the granted requester only; killed grants still push an owner bit.
REQ-020 Pointers wrap modulo OWNER_DEPTH; occupancy counter is log2(OWNER_DEPTH)+1 bits.

Reset
REQ-021 On rst_ni low: FIFO empty, counter 0, replay slot empty, orphan_err_o=0, all valid/ready outputs 0; asserting reset mid-transaction discards all outstanding state.
REQ-022 flush_i clears the replay slot next edge; owner FIFO is not flushed.

Configuration
REQ-023 Macro DCACHE_ARB_PTW_REPLAY_EN defined: a PTW-owned nack is not forwarded (ptw_resp_valid_o=0); addr/typ stored in the replay slot and reissued per REQ-011; ptw_req_ready_o=0 while the slot is occupied.
REQ-024 Macro undefined: no replay slot; PTW nack is forwarded with ptw_resp_nack_o=1; replay priority level absent.

Verification
REQ-025 PTW and core valid same cycle, dc ready=1 -> PTW granted, phys=1, cmd=0; core granted next cycle.
REQ-026 PTW valid continuously, core valid, STARVE_LIMIT=8 -> core granted on 9th grant cycle.
REQ-027 Four grants with dc_resp withheld, OWNER_DEPTH=4 -> both readys 0; one response pops -> grant resumes same cycle.
REQ-028 Owner order core,PTW; responses data 0xA,0xB -> core_resp data 0xA, then ptw_resp data 0xB.
REQ-029 With DCACHE_ARB_PTW_REPLAY_EN, PTW addr 0x80001000 nacked -> no ptw_resp, same addr reissued; flush_i before reissue -> no reissue.
REQ-030 dc_resp_valid_i=1 after reset with no grants -> orphan_err_o=1 and stays 1; no resp valid asserted.

Source files
------------

// File: rtl/dcache_req_arbiter_if.sv
// dcache_req_arbiter_if
//   Bundles the three request/response channels around the data-cache
//   arbiter: the page-table walker (ptw_*), the core load/store unit
//   (core_*) and the shared data-cache port (dc_*).
//   Signal names keep the original port names, so an existing netlist
//   connection maps one-to-one onto bus.<port>.
//   Modports:
//     master - the arbiter: consumes PTW/core requests and dcache
//              responses, and drives dcache requests and PTW/core responses.
//     slave  - the surrounding environment (the opposite directions).
interface dcache_req_arbiter_if;
  // PTW request and response
  logic        ptw_req_valid_i;
  logic [39:0] ptw_req_addr_i;
  logic [3:0]  ptw_req_typ_i;
  logic        ptw_req_kill_i;
  logic        ptw_req_ready_o;
  logic        ptw_resp_valid_o;
  logic [63:0] ptw_resp_data_o;
  logic        ptw_resp_nack_o;
  // Core request and response
  logic        core_req_valid_i;
  logic [39:0] core_req_addr_i;
  logic [63:0] core_req_data_i;
  logic [4:0]  core_req_cmd_i;
  logic [3:0]  core_req_typ_i;
  logic        core_req_kill_i;
  logic        core_req_ready_o;
  logic        core_resp_valid_o;
  logic [63:0] core_resp_data_o;
  logic        core_resp_nack_o;
  // Shared dcache port
  logic        dc_req_valid_o;
  logic [39:0] dc_req_addr_o;
  logic [63:0] dc_req_data_o;
  logic [4:0]  dc_req_cmd_o;
  logic [3:0]  dc_req_typ_o;
  logic        dc_req_kill_o;
  logic        dc_req_phys_o;
  logic        dc_req_ready_i;
  logic        dc_resp_valid_i;
  logic [63:0] dc_resp_data_i;
  logic        dc_resp_nack_i;

  modport master (
    input  ptw_req_valid_i, ptw_req_addr_i, ptw_req_typ_i, ptw_req_kill_i,
    output ptw_req_ready_o, ptw_resp_valid_o, ptw_resp_data_o, ptw_resp_nack_o,
    input  core_req_valid_i, core_req_addr_i, core_req_data_i, core_req_cmd_i,
    input  core_req_typ_i, core_req_kill_i,
    output core_req_ready_o, core_resp_valid_o, core_resp_data_o, core_resp_nack_o,
    output dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_cmd_o,
    output dc_req_typ_o, dc_req_kill_o, dc_req_phys_o,
    input  dc_req_ready_i, dc_resp_valid_i, dc_resp_data_i, dc_resp_nack_i
  );

  modport slave (
    output ptw_req_valid_i, ptw_req_addr_i, ptw_req_typ_i, ptw_req_kill_i,
    input  ptw_req_ready_o, ptw_resp_valid_o, ptw_resp_data_o, ptw_resp_nack_o,
    output core_req_valid_i, core_req_addr_i, core_req_data_i, core_req_cmd_i,
    output core_req_typ_i, core_req_kill_i,
    input  core_req_ready_o, core_resp_valid_o, core_resp_data_o, core_resp_nack_o,
    input  dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_cmd_o,
    input  dc_req_typ_o, dc_req_kill_o, dc_req_phys_o,
    output dc_req_ready_i, dc_resp_valid_i, dc_resp_data_i, dc_resp_nack_i
  );
endinterface

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter
//   Shares one data-cache request port between the page-table walker and
//   the core. Requests are selected combinationally (replay slot, PTW,
//   core) with a starvation override that hands the core one grant after
//   STARVE_LIMIT consecutive PTW-side grants while it was waiting. Every
//   grant records its owner in a small FIFO so the in-order dcache
//   responses can be routed back to the right requester.
// Parameters:
//   OWNER_DEPTH  - owner FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT - consecutive PTW/replay grants before the core is forced
// Ports:
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset
//   flush_i      - sfence/satp write; drops a pending PTW replay
//   orphan_err_o - sticky: a dcache response arrived with nothing outstanding
//   bus          - PTW, core and dcache channels (dcache_req_arbiter_if.master)
// Build option:
//   DCACHE_ARB_PTW_REPLAY_EN - when defined, a nacked PTW request is held in
//   a replay slot and reissued instead of returning the nack to the PTW.
module dcache_req_arbiter #(
  parameter int unsigned OWNER_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  orphan_err_o,
  dcache_req_arbiter_if.master  bus
);

  localparam int unsigned PW = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_REPLAY,
    SEL_PTW,
    SEL_CORE
  } sel_e;

  sel_e          sel;
  logic          owner_q [OWNER_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q;
  logic          orphan_q;

  logic          pop, push, push_owner, grant, blocked, force_core;
  logic          head_owner, drop_nack, replay_vld;

  logic          req_valid;
  logic [39:0]   req_addr;
  logic [63:0]   req_data;
  logic [4:0]    req_cmd;
  logic [3:0]    req_typ;
  logic          req_kill, req_phys;

`ifdef DCACHE_ARB_PTW_REPLAY_EN
  logic          replay_vld_q;
  logic [39:0]   replay_addr_q;
  logic [3:0]    replay_typ_q;
  logic [39:0]   ptw_addr_mem [OWNER_DEPTH];
  logic [3:0]    ptw_typ_mem  [OWNER_DEPTH];
  logic          capture;

  assign replay_vld = replay_vld_q;
  assign drop_nack  = pop && head_owner && bus.dc_resp_nack_i;
  assign capture    = drop_nack;
`else
  assign replay_vld = 1'b0;
  assign drop_nack  = 1'b0;
`endif

  assign head_owner = owner_q[rd_ptr_q];
  assign pop        = bus.dc_resp_valid_i && (count_q != '0);
  // A same-cycle pop frees the slot the push needs, so a full FIFO only
  // blocks when no response is arriving.
  assign blocked    = (count_q == CW'(OWNER_DEPTH)) && !pop;
  assign force_core = bus.core_req_valid_i && (starve_q >= SW'(STARVE_LIMIT));

  always_comb begin
    sel = SEL_NONE;
    if (rst_ni && !blocked) begin
      if (force_core)                sel = SEL_CORE;
      else if (replay_vld)           sel = SEL_REPLAY;
      else if (bus.ptw_req_valid_i)  sel = SEL_PTW;
      else if (bus.core_req_valid_i) sel = SEL_CORE;
    end
  end

  always_comb begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_cmd   = '0;
    req_typ   = '0;
    req_kill  = 1'b0;
    req_phys  = 1'b0;
    bus.ptw_req_ready_o  = 1'b0;
    bus.core_req_ready_o = 1'b0;
    unique case (sel)
`ifdef DCACHE_ARB_PTW_REPLAY_EN
      SEL_REPLAY: begin
        req_valid = 1'b1;
        req_addr  = replay_addr_q;
        req_typ   = replay_typ_q;
        req_phys  = 1'b1;
      end
`endif
      SEL_PTW: begin
        req_valid = 1'b1;
        req_addr  = bus.ptw_req_addr_i;
        req_typ   = bus.ptw_req_typ_i;
        req_kill  = bus.ptw_req_kill_i;
        req_phys  = 1'b1;
        bus.ptw_req_ready_o = bus.dc_req_ready_i;
      end
      SEL_CORE: begin
        req_valid = 1'b1;
        req_addr  = bus.core_req_addr_i;
        req_data  = bus.core_req_data_i;
        req_cmd   = bus.core_req_cmd_i;
        req_typ   = bus.core_req_typ_i;
        req_kill  = bus.core_req_kill_i;
        bus.core_req_ready_o = bus.dc_req_ready_i;
      end
      default: ;
    endcase
  end

  assign bus.dc_req_valid_o = req_valid;
  assign bus.dc_req_addr_o  = req_addr;
  assign bus.dc_req_data_o  = req_data;
  assign bus.dc_req_cmd_o   = req_cmd;
  assign bus.dc_req_typ_o   = req_typ;
  assign bus.dc_req_kill_o  = req_kill;
  assign bus.dc_req_phys_o  = req_phys;

  assign grant      = req_valid && bus.dc_req_ready_i;
  assign push       = grant;
  assign push_owner = (sel != SEL_CORE);

  assign bus.ptw_resp_valid_o  = rst_ni && pop && head_owner && !drop_nack;
  assign bus.ptw_resp_data_o   = bus.dc_resp_data_i;
  assign bus.ptw_resp_nack_o   = bus.dc_resp_nack_i;
  assign bus.core_resp_valid_o = rst_ni && pop && !head_owner;
  assign bus.core_resp_data_o  = bus.dc_resp_data_i;
  assign bus.core_resp_nack_o  = bus.dc_resp_nack_i;
  assign orphan_err_o          = orphan_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      orphan_q <= 1'b0;
      for (int unsigned i = 0; i < OWNER_DEPTH; i++) owner_q[i] <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= push_owner;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);

      if (bus.dc_resp_valid_i && (count_q == '0)) orphan_q <= 1'b1;

      if (grant) begin
        if (sel == SEL_CORE)                         starve_q <= '0;
        else if (!bus.core_req_valid_i)              starve_q <= '0;
        else if (starve_q < SW'(STARVE_LIMIT))       starve_q <= starve_q + SW'(1);
      end else if (!bus.core_req_valid_i) begin
        starve_q <= '0;
      end
    end
  end

`ifdef DCACHE_ARB_PTW_REPLAY_EN
  // Address/type of each PTW-owned entry, so a nack can be replayed exactly.
  always_ff @(posedge clk_i) begin
    if (push && push_owner) begin
      ptw_addr_mem[wr_ptr_q] <= req_addr;
      ptw_typ_mem[wr_ptr_q]  <= req_typ;
    end
  end

  // Flush wins over a same-cycle capture: the nacked walk is stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      replay_vld_q  <= 1'b0;
      replay_addr_q <= '0;
      replay_typ_q  <= '0;
    end else if (flush_i) begin
      replay_vld_q  <= 1'b0;
    end else if (capture) begin
      replay_vld_q  <= 1'b1;
      replay_addr_q <= ptw_addr_mem[rd_ptr_q];
      replay_typ_q  <= ptw_typ_mem[rd_ptr_q];
    end else if (grant && (sel == SEL_REPLAY)) begin
      replay_vld_q  <= 1'b0;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
module tb_dcache_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic orphan;
  int   checks = 0;
  int   errors = 0;

  dcache_req_arbiter_if bus();

  dcache_req_arbiter #(.OWNER_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .orphan_err_o(orphan),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ptw_req_valid_i  = 1'b0;
    bus.ptw_req_addr_i   = '0;
    bus.ptw_req_typ_i    = '0;
    bus.ptw_req_kill_i   = 1'b0;
    bus.core_req_valid_i = 1'b0;
    bus.core_req_addr_i  = '0;
    bus.core_req_data_i  = '0;
    bus.core_req_cmd_i   = '0;
    bus.core_req_typ_i   = '0;
    bus.core_req_kill_i  = 1'b0;
    bus.dc_req_ready_i   = 1'b1;
    bus.dc_resp_valid_i  = 1'b0;
    bus.dc_resp_data_i   = '0;
    bus.dc_resp_nack_i   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // ---- reset holds everything quiet even with inputs active
    rst_n = 1'b0; flush = 1'b0; idle();
    bus.ptw_req_valid_i = 1'b1; bus.core_req_valid_i = 1'b1; bus.dc_resp_valid_i = 1'b1;
    #1;
    chk("rst_dc_valid", bus.dc_req_valid_o, 0);
    chk("rst_ptw_ready", bus.ptw_req_ready_o, 0);
    chk("rst_core_ready", bus.core_req_ready_o, 0);
    chk("rst_ptw_resp", bus.ptw_resp_valid_o, 0);
    chk("rst_core_resp", bus.core_resp_valid_o, 0);
    repeat (2) @(negedge clk);
    chk("rst_orphan", orphan, 0);
    idle(); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_dc_valid", bus.dc_req_valid_o, 0);

    // ---- PTW and core together: PTW first (phys, load, zero data), then core
    @(negedge clk);
    bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h12_3456_789A; bus.ptw_req_typ_i = 4'h3;
    bus.core_req_valid_i = 1; bus.core_req_addr_i = 40'hAA_0000_1000;
    bus.core_req_data_i = 64'hDEAD; bus.core_req_cmd_i = 5'h1; bus.core_req_typ_i = 4'h2;
    #1;
    chk("both_addr", bus.dc_req_addr_o, 64'h12_3456_789A);
    chk("both_phys", bus.dc_req_phys_o, 1);
    chk("both_cmd", bus.dc_req_cmd_o, 0);
    chk("both_data", bus.dc_req_data_o, 0);
    chk("both_ptw_ready", bus.ptw_req_ready_o, 1);
    chk("both_core_ready", bus.core_req_ready_o, 0);
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    #1;
    chk("core_addr", bus.dc_req_addr_o, 64'hAA_0000_1000);
    chk("core_phys", bus.dc_req_phys_o, 0);
    chk("core_cmd", bus.dc_req_cmd_o, 1);
    chk("core_data", bus.dc_req_data_o, 64'hDEAD);
    chk("core_typ", bus.dc_req_typ_o, 2);
    chk("core_ready", bus.core_req_ready_o, 1);
    // owners now PTW, core
    @(negedge clk);
    bus.core_req_valid_i = 0;
    bus.dc_resp_valid_i = 1; bus.dc_resp_data_i = 64'h55;
    #1;
    chk("r1_ptw_valid", bus.ptw_resp_valid_o, 1);
    chk("r1_core_valid", bus.core_resp_valid_o, 0);
    chk("r1_ptw_data", bus.ptw_resp_data_o, 64'h55);
    @(negedge clk);
    bus.dc_resp_data_i = 64'h66;
    #1;
    chk("r2_core_valid", bus.core_resp_valid_o, 1);
    chk("r2_ptw_valid", bus.ptw_resp_valid_o, 0);
    chk("r2_core_data", bus.core_resp_data_o, 64'h66);

    // ---- owner order core then PTW, responses 0xA then 0xB
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    bus.core_req_valid_i = 1;
    @(negedge clk);
    bus.core_req_valid_i = 0; bus.ptw_req_valid_i = 1;
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    bus.dc_resp_valid_i = 1; bus.dc_resp_data_i = 64'hA;
    #1;
    chk("ordA_core_valid", bus.core_resp_valid_o, 1);
    chk("ordA_ptw_valid", bus.ptw_resp_valid_o, 0);
    chk("ordA_core_data", bus.core_resp_data_o, 64'hA);
    @(negedge clk);
    bus.dc_resp_data_i = 64'hB;
    #1;
    chk("ordB_ptw_valid", bus.ptw_resp_valid_o, 1);
    chk("ordB_core_valid", bus.core_resp_valid_o, 0);
    chk("ordB_ptw_data", bus.ptw_resp_data_o, 64'hB);

    // ---- kill follows only the granted requester
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    bus.ptw_req_valid_i = 1; bus.ptw_req_kill_i = 0;
    bus.core_req_valid_i = 1; bus.core_req_kill_i = 1;
    #1;
    chk("kill_ptw_sel", bus.dc_req_kill_o, 0);
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    #1;
    chk("kill_core_sel", bus.dc_req_kill_o, 1);
    @(negedge clk);
    bus.core_req_valid_i = 0; bus.core_req_kill_i = 0;
    bus.dc_resp_valid_i = 1;
    #1;
    chk("kill_pop1_ptw", bus.ptw_resp_valid_o, 1);
    @(negedge clk);
    #1;
    chk("kill_pop2_core", bus.core_resp_valid_o, 1);

    // ---- owner FIFO full blocks; a same-cycle pop lets a grant through
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    bus.core_req_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_core_ready", bus.core_req_ready_o, 1);
      @(negedge clk);
    end
    #1;
    chk("full_dc_valid", bus.dc_req_valid_o, 0);
    chk("full_core_ready", bus.core_req_ready_o, 0);
    chk("full_ptw_ready", bus.ptw_req_ready_o, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 1; bus.dc_resp_data_i = 64'h11;
    #1;
    chk("full_pop_dc_valid", bus.dc_req_valid_o, 1);
    chk("full_pop_core_ready", bus.core_req_ready_o, 1);
    chk("full_pop_resp", bus.core_resp_valid_o, 1);
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    #1;
    chk("still_full_dc_valid", bus.dc_req_valid_o, 0);
    @(negedge clk);
    bus.core_req_valid_i = 0;
    bus.dc_resp_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_core_resp", bus.core_resp_valid_o, 1);
      @(negedge clk);
    end
    bus.dc_resp_valid_i = 0;
    #1;
    chk("drained_no_resp", bus.core_resp_valid_o, 0);

    // ---- starvation: 8 PTW grants, core forced on the 9th, PTW again on the 10th
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.ptw_req_valid_i = 1; bus.core_req_valid_i = 1;
      bus.dc_resp_valid_i = (i > 1);
      #1;
      chk("starve_ptw_ready", bus.ptw_req_ready_o, (i == 9) ? 0 : 1);
      chk("starve_core_ready", bus.core_req_ready_o, (i == 9) ? 1 : 0);
    end
    @(negedge clk);
    bus.ptw_req_valid_i = 0; bus.core_req_valid_i = 0;
    bus.dc_resp_valid_i = 1;
    #1;
    chk("starve_drain_ptw", bus.ptw_resp_valid_o, 1);

    // ---- PTW nack handling
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h80001000; bus.ptw_req_typ_i = 4'h3;
    #1;
    chk("nack_req_addr", bus.dc_req_addr_o, 64'h80001000);
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    bus.dc_resp_valid_i = 1; bus.dc_resp_nack_i = 1; bus.dc_resp_data_i = 64'h77;
    #1;
`ifdef DCACHE_ARB_PTW_REPLAY_EN
    chk("rp_no_ptw_resp", bus.ptw_resp_valid_o, 0);
    chk("rp_no_core_resp", bus.core_resp_valid_o, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 0; bus.dc_resp_nack_i = 0;
    bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h1234;
    #1;
    chk("rp_reissue_valid", bus.dc_req_valid_o, 1);
    chk("rp_reissue_addr", bus.dc_req_addr_o, 64'h80001000);
    chk("rp_reissue_phys", bus.dc_req_phys_o, 1);
    chk("rp_ptw_ready", bus.ptw_req_ready_o, 0);
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    bus.dc_resp_valid_i = 1;
    #1;
    chk("rp_slot_cleared", bus.dc_req_valid_o, 0);
    chk("rp_ack_resp", bus.ptw_resp_valid_o, 1);
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h80001000;
    @(negedge clk);
    bus.ptw_req_valid_i = 0;
    bus.dc_resp_valid_i = 1; bus.dc_resp_nack_i = 1;
    #1;
    chk("rp2_no_ptw_resp", bus.ptw_resp_valid_o, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 0; bus.dc_resp_nack_i = 0;
    bus.dc_req_ready_i = 0; flush = 1;
    #1;
    chk("rp2_pending_addr", bus.dc_req_addr_o, 64'h80001000);
    @(negedge clk);
    flush = 0; bus.dc_req_ready_i = 1;
    #1;
    chk("rp2_flushed", bus.dc_req_valid_o, 0);
`else
    chk("nack_ptw_valid", bus.ptw_resp_valid_o, 1);
    chk("nack_ptw_nack", bus.ptw_resp_nack_o, 1);
    chk("nack_ptw_data", bus.ptw_resp_data_o, 64'h77);
    @(negedge clk);
    bus.dc_resp_valid_i = 0; bus.dc_resp_nack_i = 0;
    #1;
    chk("nack_no_reissue", bus.dc_req_valid_o, 0);
`endif

    // ---- dcache not ready: presented, no ready to the requester
    @(negedge clk);
    bus.dc_req_ready_i = 0; bus.ptw_req_valid_i = 1;
    #1;
    chk("stall_dc_valid", bus.dc_req_valid_o, 1);
    chk("stall_ptw_ready", bus.ptw_req_ready_o, 0);

    // ---- reset mid-transaction discards the outstanding grant
    @(negedge clk);
    bus.dc_req_ready_i = 1; bus.ptw_req_valid_i = 0;
    bus.core_req_valid_i = 1;
    @(negedge clk);
    bus.core_req_valid_i = 0;
    rst_n = 0;
    #1;
    chk("midrst_dc_valid", bus.dc_req_valid_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    bus.dc_resp_valid_i = 1; bus.dc_resp_data_i = 64'h99;
    #1;
    chk("orph_core_resp", bus.core_resp_valid_o, 0);
    chk("orph_ptw_resp", bus.ptw_resp_valid_o, 0);
    chk("orph_before_edge", orphan, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 0;
    #1;
    chk("orph_set", orphan, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("orph_sticky", orphan, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
